snap64_capture_ctrl: RTL and testbench

SNAP64_CAPTURE_CTRL -- requirements
Module: snap64_capture_ctrl

---
 rtl/snap64_capture_ctrl.sv | 114 +++++++++++
 tb/tb_snap64_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snap64_capture_ctrl.sv
// Capture controller for a 64-bit snapshot buffer: arm/trigger sequencing, buffer writes, status word.
// Optional build macro SNAP64_CTRL_CIRC_EN: circular buffer with a stop control bit.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | after reset, no capture armed
// WAIT_TRIG | armed, pointer at 0, waiting for trigger
// CAPTURE   | writing each valid sample, pointer post-increments
// DONE      | capture finished, status holds last written address
module snap64_capture_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic [31:0]       ctrl_in,
    input  logic              trig_in,
    input  logic              data_valid_in,
    input  logic [63:0]       data_in,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [63:0]       bram_data,
    output logic [31:0]       status_out
);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt, last_addr;
    logic              arm_q, stop_q;
    logic              arm_edge, stop_edge, trig_hit, wr_en;
    logic              unused_ctrl;

    assign arm_edge = ctrl_in[0] & ~arm_q;
    assign trig_hit = ~ctrl_in[1] | trig_in;

`ifdef SNAP64_CTRL_CIRC_EN
    assign stop_edge   = ctrl_in[3] & ~stop_q;
    assign unused_ctrl = ^{ctrl_in[31:4], ctrl_in[2]};
`else
    assign stop_edge   = 1'b0;
    assign unused_ctrl = ^{ctrl_in[31:2], stop_q};
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wr_en     = 1'b0;
        // A fresh arm outranks everything, including a coincident sample.
        if (arm_edge) begin
            state_nxt = WAIT_TRIG;
            ptr_nxt   = '0;
        end else begin
            case (state)
                WAIT_TRIG: begin
                    if (trig_hit) begin
                        state_nxt = CAPTURE;
                        wr_en     = data_valid_in;
                    end
                end
                CAPTURE: begin
                    if (stop_edge) state_nxt = DONE;
                    else           wr_en     = data_valid_in;
                end
                default: ;
            endcase
            if (wr_en) begin
                ptr_nxt = ptr + ADDR_W'(1);
`ifndef SNAP64_CTRL_CIRC_EN
                if (ptr == PTR_MAX) state_nxt = DONE;
`endif
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ptr       <= '0;
            last_addr <= '0;
            arm_q     <= 1'b0;
            stop_q    <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            ptr     <= ptr_nxt;
            arm_q   <= ctrl_in[0];
            stop_q  <= ctrl_in[3];
            bram_we <= wr_en;
            if (wr_en) begin
                bram_addr <= ptr;
                bram_data <= data_in;
                last_addr <= ptr;
            end else if (arm_edge) begin
                last_addr <= '0;
            end
        end
    end

    always_comb begin
        status_out               = '0;
        status_out[ADDR_W-1:0]   = last_addr;
        status_out[29]           = (state == CAPTURE);
        status_out[30]           = (state == WAIT_TRIG);
        status_out[31]           = (state == DONE);
    end

endmodule

// File: tb/tb_snap64_capture_ctrl.sv
// Self-checking bench for snap64_capture_ctrl (ADDR_W=4): directed scenarios plus random traffic
// compared against a flag/integer reference model of the capture rules.
module tb_snap64_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef SNAP64_CTRL_CIRC_EN
    localparam bit CIRC = 1'b1;
`else
    localparam bit CIRC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ctrl;
    logic              trig;
    logic              valid;
    logic [63:0]       data;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [63:0]       bram_data;
    logic [31:0]       status_out;

    int checks   = 0;
    int failures = 0;

    // reference model
    bit          m_wait, m_cap, m_done, m_arm_prev, m_stop_prev;
    int          m_next, m_last;
    bit          exp_we;
    int          exp_addr;
    logic [63:0] exp_data;

    snap64_capture_ctrl #(.ADDR_W(ADDR_W)) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .ctrl_in      (ctrl),
        .trig_in      (trig),
        .data_valid_in(valid),
        .data_in      (data),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_data    (bram_data),
        .status_out   (status_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[ADDR_W-1:0] = m_last[ADDR_W-1:0];
        s[29] = m_cap;
        s[30] = m_wait;
        s[31] = m_done;
        return s;
    endfunction

    // Applies the capture rules to the inputs about to be clocked in.
    task automatic model_tick();
        bit arm_e, stop_e, take;
        arm_e  = ctrl[0] && !m_arm_prev;
        stop_e = CIRC && ctrl[3] && !m_stop_prev;
        take   = 1'b0;
        exp_we = 1'b0;
        if (rst) begin
            {m_wait, m_cap, m_done, m_arm_prev, m_stop_prev} = '0;
            m_next = 0; m_last = 0; exp_addr = 0; exp_data = '0;
            return;
        end
        if (arm_e) begin
            m_wait = 1; m_cap = 0; m_done = 0; m_next = 0; m_last = 0;
        end else if (m_wait) begin
            if (!ctrl[1] || trig) begin
                m_wait = 0; m_cap = 1; take = valid;
            end
        end else if (m_cap) begin
            if (stop_e) begin m_cap = 0; m_done = 1; end
            else take = valid;
        end
        if (take) begin
            exp_we = 1; exp_addr = m_next; exp_data = data; m_last = m_next;
            if (m_next == DEPTH - 1) begin
                m_next = 0;
                if (!CIRC) begin m_cap = 0; m_done = 1; end
            end else begin
                m_next++;
            end
        end
        m_arm_prev  = ctrl[0];
        m_stop_prev = ctrl[3];
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check("bram_we", 64'(bram_we), 64'(exp_we));
        check("bram_addr", 64'(bram_addr), 64'(exp_addr[ADDR_W-1:0]));
        check("bram_data", bram_data, exp_data);
        check("status", 64'(status_out), 64'(exp_status()));
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic arm(input bit ext);
        ctrl = 32'd0; ctrl[1] = ext; ctrl[0] = 1'b1;
        step();
        ctrl[0] = 1'b0;
    endtask

    initial begin
        int nwr;
        int addrs[$];
        logic [63:0] tdata;

        rst = 1; ctrl = 0; trig = 0; valid = 0; data = 0;
        step(); step();
        check("reset_status", 64'(status_out), 64'd0);
        check("reset_we", 64'(bram_we), 64'd0);
        rst = 0;
        step();

        // immediate mode, continuous valid, fills the buffer
        valid = 1;
        arm(1'b0);
        nwr = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            data = rnd64();
            step();
            if (bram_we) nwr++;
        end
`ifndef SNAP64_CTRL_CIRC_EN
        check("full_writes", 64'(nwr), 64'(DEPTH));
        check("full_done", 64'(status_out[31]), 64'd1);
        check("full_last", 64'(status_out[3:0]), 64'd15);
`endif

        // external trigger held off for 20 cycles
        arm(1'b1);
        for (int i = 0; i < 20; i++) begin
            data = rnd64();
            step();
            check("ext_wait_we", 64'(bram_we), 64'd0);
            check("ext_wait_bit30", 64'(status_out[30]), 64'd1);
        end
        trig = 1; tdata = rnd64(); data = tdata;
        step();
        check("ext_first_we", 64'(bram_we), 64'd1);
        check("ext_first_addr", 64'(bram_addr), 64'd0);
        check("ext_first_data", bram_data, tdata);
        trig = 0;
        for (int i = 0; i < 3; i++) begin data = rnd64(); step(); end

        // toggling valid gives gap-free addresses
        valid = 0;
        arm(1'b0);
        addrs.delete();
        for (int i = 0; i < 8; i++) begin
            valid = (i % 2 == 0); data = rnd64();
            step();
            if (bram_we) addrs.push_back(int'(bram_addr));
        end
        check("toggle_count", 64'(addrs.size()), 64'd4);
        foreach (addrs[i]) check("toggle_addr", 64'(addrs[i]), 64'(i));

        // re-arm at address 7 with a valid sample present
        valid = 1;
        arm(1'b0);
        for (int i = 0; i < 7; i++) begin data = rnd64(); step(); end
        ctrl[0] = 1; data = rnd64();
        step();
        check("rearm_we", 64'(bram_we), 64'd0);
        check("rearm_bit30", 64'(status_out[30]), 64'd1);
        check("rearm_last", 64'(status_out[3:0]), 64'd0);
        ctrl[0] = 0; data = rnd64();
        step();
        check("rearm_restart_addr", 64'(bram_addr), 64'd0);
        check("rearm_restart_we", 64'(bram_we), 64'd1);

        // reset in the middle of a capture at address 5
        arm(1'b0);
        for (int i = 0; i < 5; i++) begin data = rnd64(); step(); end
        rst = 1; data = rnd64();
        step();
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_data", bram_data, 64'd0);
        check("rst_status", 64'(status_out), 64'd0);
        rst = 0; data = rnd64();
        step();
        check("rst_after_we", 64'(bram_we), 64'd0);
        check("rst_after_idle", 64'(status_out), 64'd0);
        arm(1'b0);
        for (int i = 0; i < 4; i++) begin data = rnd64(); step(); end

`ifdef SNAP64_CTRL_CIRC_EN
        // wrap then stop
        arm(1'b0);
        addrs.delete();
        for (int i = 0; i < 20; i++) begin
            data = rnd64(); step();
            if (bram_we) addrs.push_back(int'(bram_addr));
        end
        valid = 0; ctrl[3] = 1;
        step();
        ctrl[3] = 0;
        check("circ_count", 64'(addrs.size()), 64'd20);
        foreach (addrs[i]) check("circ_addr", 64'(addrs[i]), 64'(i % DEPTH));
        check("circ_done", 64'(status_out[31]), 64'd1);
        check("circ_last", 64'(status_out[3:0]), 64'd3);
        step();
        check("circ_no_write", 64'(bram_we), 64'd0);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            ctrl    = $urandom;
            ctrl[0] = ($urandom_range(0, 11) == 0);
            ctrl[3] = ($urandom_range(0, 7) == 0);
            trig    = ($urandom_range(0, 3) == 0);
            valid   = ($urandom_range(0, 3) != 0);
            data    = rnd64();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
